// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the program counter and sequences instruction fetch.
// Issues requests to instruction memory over a req/ready handshake, holds
// each fetched word for decode until it is consumed, and applies
// branch/jump redirects (with a sticky flag for misaligned targets).

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        Clk,
    input  logic        Reset,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,

    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        stall,

    input  logic        redirect,
    input  logic [31:0] redirect_pc,

    output logic        adel,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    fetch_state_t state;

    logic        misaligned;
    logic [31:0] redirect_target;

    // A target that is not word aligned diverts to the exception vector.
    always_comb begin
        misaligned      = (redirect_pc[1:0] != 2'b00);
        redirect_target = misaligned ? EXC_PC : redirect_pc;
    end

    // The request is only ever raised in FETCH and always points at pc,
    // so the memory sees a stable address for the whole request.
    always_comb begin
        imem_req  = (state == FETCH);
        imem_addr = pc;
    end

    // Fetch sequencer: redirect beats ready and stall; reset beats everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            adel        <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end

                FETCH: begin
                    if (redirect) begin
                        pc          <= redirect_target;
                        adel        <= adel | misaligned;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc          <= redirect_target;
                        adel        <= adel | misaligned;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl with hand-computed
// expected values for boot, wait states, stalls, redirects, misaligned
// redirects and pc wraparound.

module tb_fetch_ctrl;

    logic        Clk;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        adel;
    logic [31:0] pc;

    int totalCount = 0;
    int badCount   = 0;

    fetch_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .adel        (adel),
        .pc          (pc)
    );

    // Free-running 10-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle of inputs, clock it in, and settle 1 unit past the edge.
    task automatic applyStimulus(input logic rst, input logic rdy,
                                 input logic [31:0] rdata, input logic stl,
                                 input logic redir, input logic [31:0] rpc);
        Reset       = rst;
        imem_ready  = rdy;
        imem_rdata  = rdata;
        stall       = stl;
        redirect    = redir;
        redirect_pc = rpc;
        @(posedge Clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        Reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;

        // 1. reset two cycles with IM claiming ready
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_pc",    pc,          32'h0000_3000);
        checkOutput("rst_req",   imem_req,    32'd0);
        checkOutput("rst_valid", instr_valid, 32'd0);
        checkOutput("rst_instr", instr,       32'd0);
        checkOutput("rst_ipc",   instr_pc,    32'd0);
        checkOutput("rst_adel",  adel,        32'd0);

        // BOOT cycle: no request yet; redirect here must be ignored
        applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_5000);
        checkOutput("boot_req",  imem_req,  32'd1);
        checkOutput("boot_addr", imem_addr, 32'h0000_3000);
        checkOutput("boot_valid", instr_valid, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_valid", instr_valid, 32'd1);
        checkOutput("t1_instr", instr,       32'hA000_0001);
        checkOutput("t1_ipc",   instr_pc,    32'h0000_3000);
        checkOutput("t1_pc",    pc,          32'h0000_3004);
        checkOutput("t1_req",   imem_req,    32'd0);

        // 2. consume, then three wait cycles before ready
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_valid0", instr_valid, 32'd0);
        checkOutput("t2_req0",   imem_req,    32'd1);
        checkOutput("t2_addr0",  imem_addr,   32'h0000_3004);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
            checkOutput("t2_wait_req",  imem_req,  32'd1);
            checkOutput("t2_wait_addr", imem_addr, 32'h0000_3004);
        end
        applyStimulus(1'b0, 1'b1, 32'hB000_0002, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_instr", instr,    32'hB000_0002);
        checkOutput("t2_ipc",   instr_pc, 32'h0000_3004);
        checkOutput("t2_pc",    pc,       32'h0000_3008);

        // 3. stall in HOLD for five cycles
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h7777_7777, 1'b1, 1'b0, 32'h0);
            checkOutput("t3_instr", instr,       32'hB000_0002);
            checkOutput("t3_ipc",   instr_pc,    32'h0000_3004);
            checkOutput("t3_req",   imem_req,    32'd0);
            checkOutput("t3_valid", instr_valid, 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_resume_req",  imem_req,  32'd1);
        checkOutput("t3_resume_addr", imem_addr, 32'h0000_3008);
        checkOutput("t3_resume_valid", instr_valid, 32'd0);

        // 4. redirect with simultaneous ready: response dropped
        applyStimulus(1'b0, 1'b1, 32'hC000_0003, 1'b0, 1'b1, 32'h0000_3100);
        checkOutput("t4_pc",    pc,          32'h0000_3100);
        checkOutput("t4_valid", instr_valid, 32'd0);
        checkOutput("t4_instr", instr,       32'hB000_0002);
        checkOutput("t4_req",   imem_req,    32'd1);
        checkOutput("t4_addr",  imem_addr,   32'h0000_3100);
        applyStimulus(1'b0, 1'b1, 32'hD000_0004, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_instr2", instr,    32'hD000_0004);
        checkOutput("t4_ipc",    instr_pc, 32'h0000_3100);
        checkOutput("t4_pc2",    pc,       32'h0000_3104);

        // 5. misaligned redirect from HOLD while stalled
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3102);
        checkOutput("t5_pc",    pc,          32'h0000_4180);
        checkOutput("t5_adel",  adel,        32'd1);
        checkOutput("t5_valid", instr_valid, 32'd0);
        checkOutput("t5_addr",  imem_addr,   32'h0000_4180);
        applyStimulus(1'b0, 1'b1, 32'hE000_0005, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_ipc",   instr_pc, 32'h0000_4180);
        checkOutput("t5_pc2",   pc,       32'h0000_4184);
        checkOutput("t5_adel2", adel,     32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_adel3", adel,     32'd1);
        checkOutput("t5_req",   imem_req, 32'd1);
        // reset mid-fetch with IM ready: response ignored
        applyStimulus(1'b1, 1'b1, 32'hF000_0006, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_rst_adel",  adel,        32'd0);
        checkOutput("t5_rst_pc",    pc,          32'h0000_3000);
        checkOutput("t5_rst_instr", instr,       32'd0);
        checkOutput("t5_rst_req",   imem_req,    32'd0);
        checkOutput("t5_rst_valid", instr_valid, 32'd0);

        // 6. redirect to top of address space, pc+4 wraps
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_addr0", imem_addr, 32'h0000_3000);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("t6_pc",   pc,        32'hFFFF_FFFC);
        checkOutput("t6_adel", adel,      32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_ipc",   instr_pc, 32'hFFFF_FFFC);
        checkOutput("t6_instr", instr,    32'h1234_5678);
        checkOutput("t6_wrap",  pc,       32'h0000_0000);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
